hmmm_loader: RTL and testbench



---
 rtl/hmmm_loader.sv | 130 +++++++++++++
 tb/tb_hmmm_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hmmm_loader.sv
// hmmm_loader: framed byte-stream program loader for the hmmm core; optional checksum via HMMM_LOADER_CHECKSUM_EN.
// Latency: 4 cycles/word back-to-back; rx_ready drops only during the ADDR/DATA strobe cycles.
module hmmm_loader #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        pgrm_addr,
  output logic        pgrm_data,
  output logic [15:0] prog_data,
  output logic        cpu_rst,
  output logic        loading,
  output logic        done,
  output logic        error,
  output logic [8:0]  word_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_ADDR, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t      state, nxt;
  logic [8:0]  n_words;
  logic [7:0]  addr, hi_q, lo_q;
  logic        rx_fire;
`ifdef HMMM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign rx_fire = rx_valid && rx_ready;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (rx_fire && rx_data == HEADER) nxt = S_COUNT;
      S_COUNT: if (rx_fire) nxt = S_HI;
      S_HI:    if (rx_fire) nxt = S_LO;
      S_LO:    if (rx_fire) nxt = S_ADDR;
      S_ADDR:  nxt = S_DATA;
      S_DATA: begin
        if (word_count + 9'd1 == n_words) begin
`ifdef HMMM_LOADER_CHECKSUM_EN
          nxt = S_CSUM;
`else
          nxt = S_RUN;
`endif
        end else begin
          nxt = S_HI;
        end
      end
`ifdef HMMM_LOADER_CHECKSUM_EN
      S_CSUM:  if (rx_fire) nxt = (rx_data == csum) ? S_RUN : S_ERR;
`endif
      S_RUN, S_ERR: if (rx_fire && rx_data == HEADER) nxt = S_COUNT;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      n_words    <= '0;
      addr       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      word_count <= '0;
      rx_ready   <= 1'b1;
      pgrm_addr  <= 1'b0;
      pgrm_data  <= 1'b0;
      prog_data  <= '0;
      cpu_rst    <= 1'b1;
      loading    <= 1'b0;
      done       <= 1'b0;
`ifdef HMMM_LOADER_CHECKSUM_EN
      csum       <= '0;
      error      <= 1'b0;
`endif
    end else begin
      state <= nxt;
      case (state)
        S_COUNT: if (rx_fire) begin
          n_words    <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          word_count <= '0;
          addr       <= '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
          csum       <= '0;
`endif
        end
        S_HI: if (rx_fire) begin
          hi_q <= rx_data;
`ifdef HMMM_LOADER_CHECKSUM_EN
          csum <= csum ^ rx_data;
`endif
        end
        S_LO: if (rx_fire) begin
          lo_q <= rx_data;
`ifdef HMMM_LOADER_CHECKSUM_EN
          csum <= csum ^ rx_data;
`endif
        end
        S_DATA: begin
          addr       <= addr + 8'd1;
          word_count <= word_count + 9'd1;
        end
        default: ;
      endcase

      rx_ready  <= !(nxt == S_ADDR || nxt == S_DATA);
      pgrm_addr <= (nxt == S_ADDR);
      pgrm_data <= (nxt == S_DATA);
      prog_data <= (nxt == S_ADDR) ? {8'h00, addr} :
                   (nxt == S_DATA) ? {hi_q, lo_q} : 16'h0000;
      cpu_rst   <= (nxt != S_RUN);
      loading   <= (nxt inside {S_COUNT, S_HI, S_LO, S_ADDR, S_DATA, S_CSUM});
      done      <= (nxt == S_RUN);
`ifdef HMMM_LOADER_CHECKSUM_EN
      error     <= (nxt == S_ERR);
`endif
    end
  end

`ifndef HMMM_LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_hmmm_loader.sv
// Directed bench for hmmm_loader: expected-write scoreboard checked every cycle plus literal timing/status checks.
`timescale 1ns/1ps
module tb_hmmm_loader;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, pgrm_addr, pgrm_data, cpu_rst, loading, done, error;
  logic [15:0] prog_data;
  logic [8:0]  word_count;

  hmmm_loader #(.HEADER(HDR)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .pgrm_addr(pgrm_addr), .pgrm_data(pgrm_data), .prog_data(prog_data),
    .cpu_rst(cpu_rst), .loading(loading), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [15:0] w; } wr_t;
  wr_t         exp_q[$];
  logic [15:0] frame_words[$];
  int          checks = 0, errors = 0;
  bit          mon_en = 1'b0, gap_en = 1'b0, prev_pa = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the next expected (addr, word), in order.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("strobe_exclusive", {31'd0, pgrm_addr && pgrm_data}, 32'd0);
      chk("rx_ready_vs_strobe", {31'd0, rx_ready}, {31'd0, !(pgrm_addr || pgrm_data)});
      chk("cpu_rst_vs_done", {31'd0, cpu_rst}, {31'd0, !done});
      if (pgrm_addr) begin
        chk("addr_write_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        chk("loading_in_addr", {31'd0, loading}, 32'd1);
        if (exp_q.size() != 0) chk("addr_value", {16'd0, prog_data}, {24'd0, exp_q[0].a});
      end else if (pgrm_data) begin
        chk("data_after_addr", {31'd0, prev_pa}, 32'd1);
        chk("data_write_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          chk("data_value", {16'd0, prog_data}, {16'd0, exp_q[0].w});
          void'(exp_q.pop_front());
        end
      end else begin
        chk("prog_data_idle", {16'd0, prog_data}, 32'd0);
      end
      prev_pa = pgrm_addr;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gap_en) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic load_frame(input bit send_hdr, input bit bad_csum);
    logic [7:0] cs = 8'h00;
    int n = frame_words.size();
    if (send_hdr) send_byte(HDR);
    send_byte(n == 256 ? 8'h00 : 8'(n));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{a: 8'(i), w: frame_words[i]});
      send_byte(frame_words[i][15:8]);
      send_byte(frame_words[i][7:0]);
      cs = cs ^ frame_words[i][15:8] ^ frame_words[i][7:0];
    end
`ifdef HMMM_LOADER_CHECKSUM_EN
    send_byte(cs ^ (bad_csum ? 8'h01 : 8'h00));
`endif
  endtask

  task automatic end_status(input bit exp_err, input logic [8:0] wc);
    int n = 0;
    while (!(done || error) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("end_done", {31'd0, done}, {31'd0, !exp_err});
    chk("end_error", {31'd0, error}, {31'd0, exp_err});
    chk("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, exp_err});
    chk("end_loading", {31'd0, loading}, 32'd0);
    chk("end_word_count", {23'd0, word_count}, {23'd0, wc});
    chk("writes_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_outputs", {25'd0, pgrm_addr, pgrm_data, loading, done, error, 2'b00}, 32'd0);
    chk("rst_word_count", {23'd0, word_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset mid-frame, while the address strobe is up.
    exp_q.push_back('{a: 8'h00, w: 16'h1122});
    send_byte(HDR); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    chk("pre_rst_addr_strobe", {31'd0, pgrm_addr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pgrm_addr", {31'd0, pgrm_addr}, 32'd0);
    chk("async_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("async_rst_loading", {31'd0, loading}, 32'd0);
    chk("async_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("async_rst_prog_data", {16'd0, prog_data}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    prev_pa = 1'b0;

    // Garbage in IDLE is dropped.
    send_byte(8'h00); send_byte(8'hFF);
    chk("garbage_idle_loading", {31'd0, loading}, 32'd0);
    chk("garbage_idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // Single word with exact per-word timing.
    exp_q.push_back('{a: 8'h00, w: 16'h1234});
    send_byte(HDR); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    chk("w1_addr_strobe", {31'd0, pgrm_addr}, 32'd1);
    chk("w1_addr_value", {16'd0, prog_data}, 32'h0000);
    @(negedge clk);
    chk("w1_data_strobe", {31'd0, pgrm_data}, 32'd1);
    chk("w1_data_value", {16'd0, prog_data}, 32'h1234);
    @(negedge clk);
`ifdef HMMM_LOADER_CHECKSUM_EN
    chk("w1_csum_wait_done", {31'd0, done}, 32'd0);
    send_byte(8'h26);
`endif
    chk("w1_done", {31'd0, done}, 32'd1);
    chk("w1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("w1_word_count", {23'd0, word_count}, 32'd1);
    chk("w1_rx_ready", {31'd0, rx_ready}, 32'd1);
    send_byte(8'h5A);
    chk("garbage_run_done", {31'd0, done}, 32'd1);

    // Reload from RUN: the core goes back into reset on the header.
    send_byte(HDR);
    chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reload_loading", {31'd0, loading}, 32'd1);
    frame_words = '{16'h0001, 16'h0002, 16'h0004};
    load_frame(1'b0, 1'b0);
    end_status(1'b0, 9'd3);

`ifdef HMMM_LOADER_CHECKSUM_EN
    load_frame(1'b1, 1'b1);
    end_status(1'b1, 9'd3);
    send_byte(HDR);
    chk("err_clear_error", {31'd0, error}, 32'd0);
    chk("err_clear_loading", {31'd0, loading}, 32'd1);
    frame_words = '{16'hA5A5, 16'h00A5};
    gap_en = 1'b1;
    load_frame(1'b0, 1'b0);
    gap_en = 1'b0;
    end_status(1'b0, 9'd2);
`endif

    // Header value inside the frame is plain data; irregular rx_valid.
    frame_words = '{16'hA5A5, 16'h00A5, 16'hBEEF, 16'hA500};
    gap_en = 1'b1;
    load_frame(1'b1, 1'b0);
    gap_en = 1'b0;
    end_status(1'b0, 9'd4);

    // Count byte 0 means 256 words; addresses wrap through 0x00..0xFF.
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back(16'(i * 257) ^ 16'h0F3C);
    load_frame(1'b1, 1'b0);
    end_status(1'b0, 9'd256);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
